// File: rtl/timer.sv
// Programmable timer (TIMA/TMA/TAC): counts falling edges of a TAC-selected divider tap, reloads from TMA on overflow.
// Latency: register writes land on the mcyc edge; reads are combinational. No backpressure: bus accesses always complete.
// Backpressure: none; the interrupt request is a single-clk pulse at the reload edge.
module timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       mcyc,
    input  logic       ff04_ff07,
    input  logic [1:0] a,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    inout  tri   [7:0] d,
    input  logic       tap_4096,
    input  logic       tap_262144,
    input  logic       tap_65536,
    input  logic       tap_16384,
    output logic       int_timer,
    output logic       tima_ovf
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OVF    = 2'd1,
        RELOAD = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] tima_q, tima_d;
    logic [7:0] tma_q, tma_d;
    logic [2:0] tac_q, tac_d;
    logic       sel, sel_q, inc;
    logic       wr_any, wr_tima, wr_tma, wr_tac;
    logic       rd_en;
    logic [7:0] rd_dat;

    assign wr_any  = ff04_ff07 & cpu_wr & mcyc;
    assign wr_tima = wr_any & (a == 2'b01);
    assign wr_tma  = wr_any & (a == 2'b10);
    assign wr_tac  = wr_any & (a == 2'b11);

    always_comb begin
        sel = 1'b0;
        case (tac_q[1:0])
            2'b00: sel = tap_4096;
            2'b01: sel = tap_262144;
            2'b10: sel = tap_65536;
            2'b11: sel = tap_16384;
            default: sel = 1'b0;
        endcase
        sel = sel & tac_q[2];
    end

    // Any 1->0 drop of sel counts, including ones caused by a TAC write.
    assign inc = sel_q & ~sel;

    assign rd_en = ff04_ff07 & cpu_rd & (a != 2'b00);

    always_comb begin
        rd_dat = 8'h00;
        case (a)
            2'b01:   rd_dat = tima_q;
            2'b10:   rd_dat = tma_q;
            2'b11:   rd_dat = {5'b11111, tac_q};
            default: rd_dat = 8'h00;
        endcase
    end

    assign d = rd_en ? rd_dat : 8'bz;

    always_comb begin
        state_d   = state_q;
        tima_d    = tima_q;
        tma_d     = wr_tma ? d : tma_q;
        tac_d     = wr_tac ? d[2:0] : tac_q;
        int_timer = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_tima) begin
                    tima_d = d;
                end else if (inc) begin
                    if (tima_q == 8'hff) begin
                        tima_d  = 8'h00;
                        state_d = OVF;
                    end else begin
                        tima_d = tima_q + 8'd1;
                    end
                end
            end
            OVF: begin
                if (wr_tima) begin
                    tima_d  = d;
                    state_d = IDLE;
                end else if (mcyc) begin
                    // tma_d already folds in a same-cycle TMA write.
                    tima_d    = tma_d;
                    int_timer = 1'b1;
                    state_d   = RELOAD;
                end
            end
            RELOAD: begin
                if (wr_tma) tima_d = d;
                if (mcyc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset) int_timer = 1'b0;
    end

    assign tima_ovf = (state_q == OVF);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tima_q  <= 8'h00;
            tma_q   <= 8'h00;
            tac_q   <= 3'b000;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tima_q  <= tima_d;
            tma_q   <= tma_d;
            tac_q   <= tac_d;
            sel_q   <= sel;
        end
    end

endmodule

// File: tb/tb_timer.sv
// Bench for timer: scoreboard of expected bus reads and status values, checked at the falling clock edge.
module tb_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ff04_ff07 = 1'b0;
    logic [1:0] a = 2'b00;
    logic       cpu_wr = 1'b0;
    logic       cpu_rd = 1'b0;
    logic       tap_4096 = 1'b0, tap_262144 = 1'b0, tap_65536 = 1'b0, tap_16384 = 1'b0;
    logic       int_timer, tima_ovf;
    logic [7:0] d_drv = 8'h00;
    logic       d_oe = 1'b0;
    tri   [7:0] d;
    logic [1:0] mcyc_cnt = 2'd0;
    logic       mcyc;

    int errors = 0;
    int checks = 0;
    int int_cnt = 0;
    logic [7:0] exp_q[$];

    assign d    = d_oe ? d_drv : 8'bz;
    assign mcyc = (mcyc_cnt == 2'd3);

    always #5 clk = ~clk;
    always @(posedge clk) mcyc_cnt <= mcyc_cnt + 2'd1;
    always @(negedge clk) if (int_timer) int_cnt = int_cnt + 1;

    timer dut (
        .clk(clk), .reset(reset), .mcyc(mcyc), .ff04_ff07(ff04_ff07), .a(a),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .d(d),
        .tap_4096(tap_4096), .tap_262144(tap_262144), .tap_65536(tap_65536), .tap_16384(tap_16384),
        .int_timer(int_timer), .tima_ovf(tima_ovf)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input logic [7:0] exp);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop_chk(input string tag, input logic [7:0] got);
        logic [7:0] exp;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 8'h01, 8'h00);
        end else begin
            exp = exp_q.pop_front();
            chk(tag, got, exp);
        end
    endtask

    task automatic cpu_write(input logic [1:0] addr, input logic [7:0] val);
        do @(negedge clk); while (!mcyc);
        ff04_ff07 = 1'b1; a = addr; cpu_wr = 1'b1; d_drv = val; d_oe = 1'b1;
        @(negedge clk);
        ff04_ff07 = 1'b0; cpu_wr = 1'b0; d_oe = 1'b0;
    endtask

    // Combinational read in the current cycle; call at a falling edge.
    task automatic cpu_read(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        sb_push(exp);
        ff04_ff07 = 1'b1; a = addr; cpu_rd = 1'b1;
        #1;
        sb_pop_chk(tag, d);
        ff04_ff07 = 1'b0; cpu_rd = 1'b0;
    endtask

    task automatic status(input string tag, input logic got, input logic exp);
        sb_push({7'd0, exp});
        sb_pop_chk(tag, {7'd0, got});
    endtask

    // Returns at the falling edge after the increment edge.
    task automatic fall_262144();
        @(negedge clk); tap_262144 = 1'b1;
        @(negedge clk); @(negedge clk); tap_262144 = 1'b0;
        @(negedge clk);
    endtask

    task automatic fall_16384();
        @(negedge clk); tap_16384 = 1'b1;
        @(negedge clk); @(negedge clk); tap_16384 = 1'b0;
        @(negedge clk);
    endtask

    // Waits (bounded) at falling edges for the interrupt pulse; leaves us in that cycle.
    task automatic wait_int(input string tag);
        int n = 0;
        while (!int_timer && n < 8) begin
            @(negedge clk);
            n++;
        end
        status(tag, (int_timer == 1'b1) && (n <= 3), 1'b1);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        cpu_read("rst_tima", 2'b01, 8'h00);
        cpu_read("rst_tma", 2'b10, 8'h00);
        cpu_read("rst_tac", 2'b11, 8'hf8);
        status("rst_int", int_timer, 1'b0);
        status("rst_ovf", tima_ovf, 1'b0);

        // Basic count at 262144 Hz.
        cpu_write(2'b11, 8'h05);
        cpu_write(2'b01, 8'h00);
        for (int i = 0; i < 16; i++) fall_262144();
        cpu_read("count16", 2'b01, 8'h10);
        cpu_read("tac05", 2'b11, 8'hfd);

        // Overflow and reload.
        cpu_write(2'b10, 8'ha0);
        cpu_write(2'b01, 8'hfe);
        cpu_write(2'b11, 8'h07);
        fall_16384();
        cpu_read("ovf_ff", 2'b01, 8'hff);
        base = int_cnt;
        fall_16384();
        status("ovf_state", tima_ovf, 1'b1);
        cpu_read("ovf_zero", 2'b01, 8'h00);
        wait_int("ovf_int_window");
        cpu_read("ovf_int_tima", 2'b01, 8'h00);
        @(negedge clk);
        cpu_read("reload_a0", 2'b01, 8'ha0);
        status("reload_ovf_clr", tima_ovf, 1'b0);
        repeat (8) @(negedge clk);
        sb_push(8'(base + 1));
        sb_pop_chk("ovf_int_once", 8'(int_cnt));

        // Cancel reload by writing TIMA during OVF.
        cpu_write(2'b01, 8'hff);
        base = int_cnt;
        fall_16384();
        status("cancel_ovf", tima_ovf, 1'b1);
        cpu_write(2'b01, 8'h33);
        cpu_read("cancel_tima", 2'b01, 8'h33);
        status("cancel_idle", tima_ovf, 1'b0);
        repeat (8) @(negedge clk);
        sb_push(8'(base));
        sb_pop_chk("cancel_no_int", 8'(int_cnt));

        // TIMA write ignored during RELOAD.
        cpu_write(2'b01, 8'hff);
        fall_16384();
        wait_int("rl1_int");
        cpu_write(2'b01, 8'h77);
        cpu_read("rl_tima_ign", 2'b01, 8'ha0);

        // TMA write during RELOAD also lands in TIMA.
        cpu_write(2'b01, 8'hff);
        fall_16384();
        wait_int("rl2_int");
        cpu_write(2'b10, 8'h55);
        cpu_read("rl_tima55", 2'b01, 8'h55);
        cpu_read("rl_tma55", 2'b10, 8'h55);

        // TAC write dropping sel produces an increment only when the tap is high.
        cpu_write(2'b11, 8'h04);
        cpu_write(2'b01, 8'h10);
        @(negedge clk); tap_4096 = 1'b1;
        repeat (2) @(negedge clk);
        cpu_write(2'b11, 8'h00);
        @(negedge clk);
        cpu_read("spur_inc", 2'b01, 8'h11);
        tap_4096 = 1'b0;
        cpu_write(2'b11, 8'h04);
        repeat (2) @(negedge clk);
        cpu_write(2'b11, 8'h00);
        @(negedge clk);
        cpu_read("spur_none", 2'b01, 8'h11);

        // Reset mid-OVF.
        cpu_write(2'b10, 8'h99);
        cpu_write(2'b11, 8'h07);
        cpu_write(2'b01, 8'hff);
        base = int_cnt;
        fall_16384();
        status("rst_pre_ovf", tima_ovf, 1'b1);
        reset = 1'b1;
        #1;
        status("rst_int_gated", int_timer, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        cpu_read("rst2_tima", 2'b01, 8'h00);
        cpu_read("rst2_tma", 2'b10, 8'h00);
        cpu_read("rst2_tac", 2'b11, 8'hf8);
        status("rst2_idle", tima_ovf, 1'b0);
        repeat (8) @(negedge clk);
        sb_push(8'(base));
        sb_pop_chk("rst2_no_int", 8'(int_cnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
